// File: rtl/shift_collector.sv
// -----------------------------------------------------------------------------
// shift_collector
//   Serial-in collector for the single-bit outputs the datapath shifter emits
//   on each 1-bit shift. A job collects up to WIDTH bits into a parallel word:
//     - Left shifts (dir=0) collect il. The first bit lands at the MSB of the
//       N-bit collected field, and the bits above the field are zero.
//     - Right shifts (dir=1) collect ir. The first bit lands at bit 0.
//   The result is presented for one cycle with o_word_valid. It is held on
//   o_word until the next job completes or reset.
//
// Ports
//   i_clock       system clock, rising edge
//   i_reset       synchronous active-high reset; overrides all other inputs
//   i_start       begin a job (samples i_dir and i_count)
//   i_dir         0 = collect i_il, 1 = collect i_ir
//   i_count       bits to collect; 0 = empty job, >WIDTH saturates to WIDTH
//   i_bit_valid   i_il / i_ir carry a valid shifted-out bit this cycle
//   i_il          bit shifted out of the MSB on a left shift
//   i_ir          bit shifted out of the LSB on a right shift
//   o_busy        job in progress
//   o_word        collected, aligned result
//   o_word_valid  one-cycle pulse when o_word is updated
//   o_overrun     sticky: a bit arrived while no job was collecting
// -----------------------------------------------------------------------------
module shift_collector #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             i_clock,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_dir,
   input  logic [CNT_W-1:0] i_count,
   input  logic             i_bit_valid,
   input  logic             i_il,
   input  logic             i_ir,
   output logic             o_busy,
   output logic [WIDTH-1:0] o_word,
   output logic             o_word_valid,
   output logic             o_overrun
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   logic             r_busy;
   logic             r_word_valid;
   logic             r_dir;
   logic [CNT_W-1:0] r_need;
   logic [CNT_W-1:0] r_got;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_word;
   logic             r_overrun;

   logic [CNT_W-1:0] w_sat_count;
   logic [WIDTH-1:0] w_next_acc;
   logic [CNT_W-1:0] w_got_next;
   logic             w_last_bit;
   logic [WIDTH-1:0] w_mask;
   logic [WIDTH-1:0] w_final_word;

   // Saturate the requested count to the datapath width.
   always_comb begin
      if (i_count > WIDTH_C) begin
         w_sat_count = WIDTH_C;
      end else begin
         w_sat_count = i_count;
      end
   end

   // Accumulator shifted by the current bit, according to the latched direction.
   always_comb begin
      if (r_dir) begin
         w_next_acc = {i_ir, r_acc[WIDTH-1:1]};
      end else begin
         w_next_acc = {r_acc[WIDTH-2:0], i_il};
      end
   end

   // Bit counting and final alignment of the collected field.
   always_comb begin
      w_got_next = r_got + ONE_C;
      w_last_bit = i_bit_valid && (w_got_next == r_need);
      // When r_need == WIDTH, the shift clears every bit, so the mask becomes all ones.
      w_mask     = ~({WIDTH{1'b1}} << r_need);
      if (r_dir) begin
         // Right-shift bits enter at the MSB and must be brought down to bit 0.
         w_final_word = w_next_acc >> (WIDTH_C - r_need);
      end else begin
         w_final_word = w_next_acc & w_mask;
      end
   end

   // Job sequencing, accumulation, result and flag registers.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_busy       <= 1'b0;
         r_word_valid <= 1'b0;
         r_dir        <= 1'b0;
         r_need       <= {CNT_W{1'b0}};
         r_got        <= {CNT_W{1'b0}};
         r_acc        <= {WIDTH{1'b0}};
         r_word       <= {WIDTH{1'b0}};
         r_overrun    <= 1'b0;
      end else begin
         case (r_state)
            // DONE lasts one cycle and accepts a new start exactly like IDLE.
            S_IDLE, S_DONE: begin
               if (i_start) begin
                  r_overrun <= 1'b0;
                  r_dir     <= i_dir;
                  r_need    <= w_sat_count;
                  r_got     <= {CNT_W{1'b0}};
                  r_acc     <= {WIDTH{1'b0}};
                  if (i_count == {CNT_W{1'b0}}) begin
                     r_state      <= S_DONE;
                     r_busy       <= 1'b0;
                     r_word_valid <= 1'b1;
                     r_word       <= {WIDTH{1'b0}};
                  end else begin
                     r_state      <= S_COLLECT;
                     r_busy       <= 1'b1;
                     r_word_valid <= 1'b0;
                  end
               end else begin
                  r_state      <= S_IDLE;
                  r_busy       <= 1'b0;
                  r_word_valid <= 1'b0;
                  if (i_bit_valid) begin
                     r_overrun <= 1'b1;
                  end
               end
            end
            // start is ignored while collecting; only bit_valid advances the job.
            S_COLLECT: begin
               if (i_bit_valid) begin
                  r_acc <= w_next_acc;
                  r_got <= w_got_next;
                  if (w_last_bit) begin
                     r_state      <= S_DONE;
                     r_busy       <= 1'b0;
                     r_word_valid <= 1'b1;
                     r_word       <= w_final_word;
                  end
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_busy       <= 1'b0;
               r_word_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy       = r_busy;
   assign o_word       = r_word;
   assign o_word_valid = r_word_valid;
   assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_shift_collector.sv
// -----------------------------------------------------------------------------
// tb_shift_collector
//   Randomized, scoreboarded bench for shift_collector. Each job's expected word
//   is computed from the bit list with plain index arithmetic when the job
//   starts, and then queued. A monitor pops an entry for each o_word_valid cycle.
// -----------------------------------------------------------------------------
module tb_shift_collector;

   localparam int WIDTH = 16;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             dir;
   logic [CNT_W-1:0] cnt;
   logic             bv;
   logic             il;
   logic             ir;
   logic             busy;
   logic [WIDTH-1:0] word;
   logic             word_valid;
   logic             overrun;

   int               n_cmp = 0;
   int               n_bad = 0;
   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] last_word;

   shift_collector #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_start      (start),
      .i_dir        (dir),
      .i_count      (cnt),
      .i_bit_valid  (bv),
      .i_il         (il),
      .i_ir         (ir),
      .o_busy       (busy),
      .o_word       (word),
      .o_word_valid (word_valid),
      .o_overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc();
      start = 1'b0;
      bv    = 1'b0;
      il    = 1'($urandom);
      ir    = 1'($urandom);
   endtask

   // Drive one job. bits[k] is the k-th bit sent. gap_max is the maximum number of
   // empty cycles before each bit. stray enables start pulses while collecting.
   task automatic run_job(input logic d, input logic [CNT_W-1:0] c,
                          input logic [WIDTH-1:0] bits, input int gap_max, input bit stray);
      int               n;
      int               g;
      bit               first;
      logic [WIDTH-1:0] e;
      n = (int'(c) > WIDTH) ? WIDTH : int'(c);
      e = '0;
      for (int k = 0; k < n; k++) begin
         if (d) e[k] = bits[k];
         else   e[n-1-k] = bits[k];
      end
      cyc();
      start = 1'b1;
      dir   = d;
      cnt   = c;
      bv    = 1'($urandom);
      il    = 1'($urandom);
      ir    = 1'($urandom);
      exp_q.push_back(e);
      first = 1'b1;
      for (int k = 0; k < n; k++) begin
         g = $urandom_range(gap_max, 0);
         for (int j = 0; j < g; j++) begin
            cyc();
            start = stray ? 1'($urandom) : 1'b0;
            dir   = 1'($urandom);
            cnt   = CNT_W'($urandom);
            bv    = 1'b0;
            il    = 1'($urandom);
            ir    = 1'($urandom);
            if (first) begin
               @(negedge clk);
               chk("busy_after_start", 32'(busy), 32'd1);
               chk("overrun_cleared", 32'(overrun), 32'd0);
               first = 1'b0;
            end
         end
         cyc();
         start = stray ? 1'($urandom) : 1'b0;
         dir   = 1'($urandom);
         cnt   = CNT_W'($urandom);
         bv    = 1'b1;
         if (d) begin
            ir = bits[k];
            il = 1'($urandom);
         end else begin
            il = bits[k];
            ir = 1'($urandom);
         end
         if (first) begin
            @(negedge clk);
            chk("busy_after_start", 32'(busy), 32'd1);
            chk("overrun_cleared", 32'(overrun), 32'd0);
            first = 1'b0;
         end
      end
   endtask

   // Scoreboard monitor: consume one expectation per word_valid cycle and check
   // that word is stable in all other cycles.
   initial begin
      logic [WIDTH-1:0] e;
      last_word = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            last_word = word;
         end else begin
            if (word_valid) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_word_valid: got word 0x%0h with nothing expected at %0t", word, $time);
               end else begin
                  e = exp_q.pop_front();
                  chk("word", 32'(word), 32'(e));
               end
            end else begin
               chk("word_stable", 32'(word), 32'(last_word));
            end
            last_word = word;
         end
      end
   end

   initial begin
      logic [WIDTH-1:0] rbits;
      rst   = 1'b1;
      start = 1'b1;
      bv    = 1'b1;
      dir   = 1'b0;
      cnt   = '0;
      il    = 1'b0;
      ir    = 1'b0;

      // Reset held 2 cycles while start and bit_valid are active.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_word", 32'(word), 32'd0);
      chk("rst_word_valid", 32'(word_valid), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      cyc();
      rst   = 1'b0;
      start = 1'b0;
      bv    = 1'b0;
      idle();

      // Left shift: il = 1,0,1,1 gives 0x000B.
      run_job(1'b0, 5'd4, 16'b1101, 0, 1'b0);
      idle();
      @(negedge clk);
      chk("left4_valid", 32'(word_valid), 32'd1);
      chk("left4_word", 32'(word), 32'h000B);
      idle();
      @(negedge clk);
      chk("left4_pulse_end", 32'(word_valid), 32'd0);

      // Right shift: ir = 1,0,1,1 gives 0x000D.
      run_job(1'b1, 5'd4, 16'b1101, 0, 1'b0);
      idle();
      @(negedge clk);
      chk("right4_valid", 32'(word_valid), 32'd1);
      chk("right4_word", 32'(word), 32'h000D);
      idle();
      @(negedge clk);
      chk("right4_pulse_end", 32'(word_valid), 32'd0);

      // 0xA5C3 sent MSB-first with random gaps between bits.
      rbits = '0;
      for (int k = 0; k < WIDTH; k++) rbits[k] = 16'hA5C3 >> (WIDTH - 1 - k);
      run_job(1'b0, 5'd16, rbits, 3, 1'b0);
      idle();
      idle();

      // Overrun while idle is sticky; a start during collection is ignored; the next start clears overrun.
      cyc();
      bv = 1'b1;
      idle();
      @(negedge clk);
      chk("overrun_set", 32'(overrun), 32'd1);
      idle();
      idle();
      @(negedge clk);
      chk("overrun_sticky", 32'(overrun), 32'd1);
      run_job(1'b1, 5'd9, 16'($urandom), 2, 1'b1);
      idle();

      // Reset in the middle of a job discards it.
      cyc();
      start = 1'b1;
      dir   = 1'b0;
      cnt   = 5'd8;
      cyc();
      start = 1'b0;
      bv    = 1'b1;
      il    = 1'b1;
      cyc();
      il    = 1'b1;
      cyc();
      rst   = 1'b1;
      bv    = 1'b0;
      cyc();
      cyc();
      rst   = 1'b0;
      @(negedge clk);
      chk("midjob_rst_busy", 32'(busy), 32'd0);
      chk("midjob_rst_word", 32'(word), 32'd0);

      // Empty job, then a saturated count of 20.
      run_job(1'b0, 5'd0, 16'h0000, 0, 1'b0);
      idle();
      @(negedge clk);
      chk("count0_valid", 32'(word_valid), 32'd1);
      chk("count0_word", 32'(word), 32'd0);
      run_job(1'b0, 5'd20, 16'($urandom), 1, 1'b0);
      idle();
      run_job(1'b1, 5'd31, 16'($urandom), 1, 1'b0);
      idle();

      // Random jobs; some run back to back through DONE.
      for (int t = 0; t < 40; t++) begin
         run_job(1'($urandom), CNT_W'($urandom_range(20, 0)), 16'($urandom),
                 $urandom_range(3, 0), 1'($urandom));
         if ($urandom_range(1, 0) == 1) idle();
      end
      idle();

      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
